// File: rtl/step_engine_dda.sv
// Multi-axis DDA step generator: takes one motion record per move and spreads each axis's
// steps evenly over the move's iterations. Define STEP_ENGINE_ABORT_EN to add abort/done_remaining.
module step_engine_dda #(
   parameter int MOTORS            = 8,
   parameter int COUNT_WIDTH       = 16,
   parameter int PERIOD_WIDTH      = 16,
   parameter int STEP_PULSE_CYCLES = 4,
   parameter int DIR_SETUP_CYCLES  = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rec_valid,
   output logic                          rec_ready,
   input  logic [COUNT_WIDTH-1:0]        rec_loops,
   input  logic [PERIOD_WIDTH-1:0]       rec_period,
   input  logic [MOTORS*COUNT_WIDTH-1:0] rec_steps,
   input  logic [MOTORS-1:0]             rec_dir,
`ifdef STEP_ENGINE_ABORT_EN
   input  logic                          abort,
   output logic [COUNT_WIDTH-1:0]        done_remaining,
`endif
   output logic [MOTORS-1:0]             step,
   output logic [MOTORS-1:0]             direction,
   output logic                          busy,
   output logic                          done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SETUP = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   localparam int SETUP_W = (DIR_SETUP_CYCLES > 1) ? $clog2(DIR_SETUP_CYCLES) : 1;
   localparam int PULSE_W = (STEP_PULSE_CYCLES > 1) ? $clog2(STEP_PULSE_CYCLES) : 1;
   localparam logic [SETUP_W-1:0]      SETUP_LOAD = SETUP_W'(DIR_SETUP_CYCLES - 1);
   localparam logic [PULSE_W-1:0]      PULSE_LOAD = PULSE_W'(STEP_PULSE_CYCLES - 1);
   // Shortest legal iteration: full pulse width plus at least one low cycle.
   localparam logic [PERIOD_WIDTH-1:0] MIN_PERIOD = PERIOD_WIDTH'(STEP_PULSE_CYCLES + 1);

   logic [1:0]              state;
   logic [SETUP_W-1:0]      setup_cnt;
   logic [PERIOD_WIDTH-1:0] period_cnt;
   logic [PERIOD_WIDTH-1:0] period_eff;
   logic [PULSE_W-1:0]      pulse_cnt;
   logic [COUNT_WIDTH-1:0]  loops_q;
   logic [COUNT_WIDTH-1:0]  loop_ctr;
   logic                    aborting;

   logic [COUNT_WIDTH-1:0]  steps_q    [MOTORS];
   logic [COUNT_WIDTH-1:0]  acc_q      [MOTORS];
   logic [COUNT_WIDTH-1:0]  acc_nxt    [MOTORS];
   logic [COUNT_WIDTH-1:0]  step_clamp [MOTORS];
   logic [COUNT_WIDTH:0]    sum_w      [MOTORS];
   logic [MOTORS-1:0]       fire;

   logic accept;
   logic abort_req;
   logic iter_due;

   assign accept = (state == S_IDLE) && rec_valid && rec_ready;
   assign busy   = (state != S_IDLE);

`ifdef STEP_ENGINE_ABORT_EN
   assign abort_req = abort && ((state == S_SETUP) || (state == S_RUN));
`else
   assign abort_req = 1'b0;
`endif

   assign iter_due = (state == S_RUN) && !abort_req && (period_cnt == '0);

   // Bresenham step decision per axis; acc < loops always, so the extra sum bit never overflows.
   always_comb begin
      // NOTE: every signal driven here gets a value on every path before use, so no latch is inferred.
      fire = '0;
      for (int i = 0; i < MOTORS; i++) begin
         step_clamp[i] = (rec_steps[i*COUNT_WIDTH +: COUNT_WIDTH] > rec_loops) ?
                         rec_loops : rec_steps[i*COUNT_WIDTH +: COUNT_WIDTH];
         sum_w[i]      = {1'b0, acc_q[i]} + {1'b0, steps_q[i]};
         acc_nxt[i]    = sum_w[i][COUNT_WIDTH-1:0];
         if (sum_w[i] >= {1'b0, loops_q}) begin
            fire[i]    = 1'b1;
            acc_nxt[i] = sum_w[i][COUNT_WIDTH-1:0] - loops_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: these per-axis arrays are plain flop banks, not a RAM, so they take the async reset.
         for (int i = 0; i < MOTORS; i++) begin
            steps_q[i] <= '0;
            acc_q[i]   <= '0;
         end
      end else if (accept) begin
         for (int i = 0; i < MOTORS; i++) begin
            steps_q[i] <= step_clamp[i];
            acc_q[i]   <= rec_loops >> 1;
         end
      end else if (iter_due) begin
         for (int i = 0; i < MOTORS; i++) begin
            acc_q[i] <= acc_nxt[i];
         end
      end
   end

   // All axes step on the same iteration edge, so one shared width timer serves every pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         step      <= '0;
         pulse_cnt <= '0;
      end else if (iter_due) begin
         step      <= fire;
         pulse_cnt <= PULSE_LOAD;
      end else if (pulse_cnt != '0) begin
         pulse_cnt <= pulse_cnt - 1'b1;
      end else begin
         step <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         direction <= '0;
      end else if (accept) begin
         direction <= rec_dir;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         rec_ready  <= 1'b0;
         done       <= 1'b0;
         setup_cnt  <= '0;
         period_cnt <= '0;
         period_eff <= '0;
         loops_q    <= '0;
         loop_ctr   <= '0;
         aborting   <= 1'b0;
`ifdef STEP_ENGINE_ABORT_EN
         done_remaining <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               rec_ready <= !accept;
               if (accept) begin
                  loops_q    <= rec_loops;
                  loop_ctr   <= rec_loops;
                  period_eff <= (rec_period < MIN_PERIOD) ? MIN_PERIOD : rec_period;
                  setup_cnt  <= SETUP_LOAD;
                  period_cnt <= '0;
                  aborting   <= 1'b0;
                  // An empty move skips direction setup and completes on the next edge.
                  state      <= (rec_loops == '0) ? S_DRAIN : S_SETUP;
               end
            end
            S_SETUP: begin
               if (abort_req) begin
                  aborting <= 1'b1;
                  state    <= S_DRAIN;
               end else if (setup_cnt == '0) begin
                  state <= S_RUN;
               end else begin
                  setup_cnt <= setup_cnt - 1'b1;
               end
            end
            S_RUN: begin
               if (abort_req) begin
                  aborting <= 1'b1;
                  state    <= S_DRAIN;
               end else if (period_cnt == '0) begin
                  loop_ctr   <= loop_ctr - 1'b1;
                  period_cnt <= period_eff - 1'b1;
                  if (loop_ctr == COUNT_WIDTH'(1)) begin
                     state <= S_DRAIN;
                  end
               end else begin
                  period_cnt <= period_cnt - 1'b1;
               end
            end
            default: begin
               // Normal moves wait out the last period; aborted moves only wait for the pulse to end.
               if (aborting ? (step == '0) : (period_cnt == '0)) begin
                  done      <= 1'b1;
                  rec_ready <= 1'b1;
                  state     <= S_IDLE;
`ifdef STEP_ENGINE_ABORT_EN
                  done_remaining <= loop_ctr;
`endif
               end else if (!aborting) begin
                  period_cnt <= period_cnt - 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_step_engine_dda.sv
// Randomised bench for step_engine_dda: every cycle of every move is compared against a
// closed-form Bresenham model of step timing, done, busy, rec_ready and direction.
module tb_step_engine_dda;

   localparam int MOTORS = 2;
   localparam int CW     = 16;
   localparam int PW     = 16;
   localparam int SPC    = 2;
   localparam int DSC    = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 rec_valid;
   logic                 rec_ready;
   logic [CW-1:0]        rec_loops;
   logic [PW-1:0]        rec_period;
   logic [MOTORS*CW-1:0] rec_steps;
   logic [MOTORS-1:0]    rec_dir;
   logic [MOTORS-1:0]    step;
   logic [MOTORS-1:0]    direction;
   logic                 busy;
   logic                 done;
`ifdef STEP_ENGINE_ABORT_EN
   logic                 abort;
   logic [CW-1:0]        done_remaining;
`endif

   int                n_vec = 0;
   int                n_err = 0;
   logic [MOTORS-1:0] last_dir;

   step_engine_dda #(
      .MOTORS(MOTORS), .COUNT_WIDTH(CW), .PERIOD_WIDTH(PW),
      .STEP_PULSE_CYCLES(SPC), .DIR_SETUP_CYCLES(DSC)
   ) dut (
      .clk(clk), .rst(rst),
      .rec_valid(rec_valid), .rec_ready(rec_ready),
      .rec_loops(rec_loops), .rec_period(rec_period),
      .rec_steps(rec_steps), .rec_dir(rec_dir),
`ifdef STEP_ENGINE_ABORT_EN
      .abort(abort), .done_remaining(done_remaining),
`endif
      .step(step), .direction(direction), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int peff_of(input int p);
      return (p < SPC + 1) ? SPC + 1 : p;
   endfunction

   // Axis with s steps over l iterations has floor((l/2 + n*s)/l) pulses after n iterations.
   function automatic bit fires(input int l, input int s, input int k);
      int h;
      h = l / 2;
      return ((h + (k + 1) * s) / l) != ((h + k * s) / l);
   endfunction

   // Entered and left on a falling edge. abort_edge = rel. edge (after accept) at which abort is sampled.
   task automatic run_move(input int l, input int p, input int s0, input int s1,
                           input logic [MOTORS-1:0] dir, input bit hold, input int abort_edge);
      int s_eff [MOTORS];
      int pulses [MOTORS];
      int exp_pulses [MOTORS];
      int pe, n_iter, t_done, last_clear, remaining, w, k, rr;
      bit any;
      logic [MOTORS-1:0] prev, exp_step;
`ifndef STEP_ENGINE_ABORT_EN
      abort_edge = -1;
`endif
      s_eff[0] = (s0 > l) ? l : s0;
      s_eff[1] = (s1 > l) ? l : s1;
      pe = peff_of(p);

      w = 0;
      while (rec_ready !== 1'b1 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", rec_ready, 1'b1);
      if (rec_ready !== 1'b1) return;
      check("dir_hold", direction, last_dir);

      rec_loops  = CW'(l);
      rec_period = PW'(p);
      rec_steps  = {CW'(s1), CW'(s0)};
      rec_dir    = dir;
      rec_valid  = 1'b1;

      n_iter = l;
      remaining = 0;
      last_clear = 0;
      if (l == 0) begin
         t_done = 1;
      end else if (abort_edge >= 1 && abort_edge <= DSC + 1 + (l - 1) * pe) begin
         n_iter = (abort_edge <= DSC + 1) ? 0 : (abort_edge - (DSC + 1) + pe - 1) / pe;
         remaining = l - n_iter;
         for (int j = 0; j < n_iter; j++) begin
            any = fires(l, s_eff[0], j) || fires(l, s_eff[1], j);
            if (any) last_clear = DSC + 1 + j * pe + SPC;
         end
         t_done = ((abort_edge > last_clear) ? abort_edge : last_clear) + 1;
      end else begin
         t_done = DSC + 1 + l * pe;
      end
      for (int m = 0; m < MOTORS; m++) begin
         pulses[m] = 0;
         exp_pulses[m] = 0;
         for (int j = 0; j < n_iter; j++) if (fires(l, s_eff[m], j)) exp_pulses[m]++;
      end

      prev = '0;
      @(posedge clk);
      for (int r = 0; r <= t_done; r++) begin
         @(negedge clk);
         exp_step = '0;
         if (r >= DSC + 1) begin
            k  = (r - (DSC + 1)) / pe;
            rr = r - (DSC + 1) - k * pe;
            if (k < n_iter && rr < SPC)
               for (int m = 0; m < MOTORS; m++) exp_step[m] = fires(l, s_eff[m], k);
         end
         check("step", step, exp_step);
         check("done", done, r == t_done);
         check("busy", busy, r < t_done);
         check("rec_ready", rec_ready, r == t_done);
         check("direction", direction, dir);
         for (int m = 0; m < MOTORS; m++) if (step[m] && !prev[m]) pulses[m]++;
         prev = step;
`ifdef STEP_ENGINE_ABORT_EN
         if (r == t_done) check("done_remaining", done_remaining, remaining);
         abort = (abort_edge >= 1) && (r + 1 == abort_edge);
`endif
         if (r == t_done || !hold) begin
            rec_valid = 1'b0;
         end else begin
            rec_loops  = CW'($urandom);
            rec_period = PW'($urandom);
            rec_steps  = $urandom;
            rec_dir    = MOTORS'($urandom);
         end
      end
      for (int m = 0; m < MOTORS; m++) check("pulses", pulses[m], exp_pulses[m]);
      last_dir = dir;
   endtask

   task automatic reset_mid_run();
      int w;
      w = 0;
      while (rec_ready !== 1'b1 && w < 1000) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait_rst", rec_ready, 1'b1);
      rec_loops  = CW'(6);
      rec_period = PW'(5);
      rec_steps  = {CW'(6), CW'(6)};
      rec_dir    = 2'b01;
      rec_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rec_valid = 1'b0;
      repeat (DSC + 1) @(negedge clk);
      check("pre_reset_step", step, 2'b11);
      #2 rst = 1'b0;
      #1;
      check("rst_step", step, 0);
      check("rst_direction", direction, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ready", rec_ready, 0);
      repeat (3) begin
         @(negedge clk);
         check("rst_hold", {step, direction, busy, done, rec_ready}, 0);
      end
      rst = 1'b1;
      #1 check("ready_before_edge", rec_ready, 0);
      @(negedge clk);
      check("ready_after_release", rec_ready, 1);
      repeat (30) begin
         @(negedge clk);
         check("discarded_move", {step, busy, done}, 0);
      end
      last_dir = '0;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int l, p, ab;
      bit hold;
      rst        = 1'b0;
      rec_valid  = 1'b0;
      rec_loops  = '0;
      rec_period = '0;
      rec_steps  = '0;
      rec_dir    = '0;
      last_dir   = '0;
`ifdef STEP_ENGINE_ABORT_EN
      abort      = 1'b0;
`endif
      repeat (3) begin
         @(negedge clk);
         check("reset_outputs", {step, direction, busy, done, rec_ready}, 0);
      end
      rst = 1'b1;
      #1 check("ready_at_release", rec_ready, 0);
      @(negedge clk);
      check("ready_first_edge", rec_ready, 1);

      run_move(4, 5, 4, 2, 2'b00, 1'b0, -1);
      run_move(0, 5, 3, 3, 2'b11, 1'b0, -1);
      run_move(3, 1, 3, 1, 2'b10, 1'b0, -1);
      run_move(4, 5, 1, 9, 2'b01, 1'b0, -1);
      run_move(5, 4, 2, 5, 2'b11, 1'b1, -1);
      run_move(6, 3, 6, 1, 2'b00, 1'b1, -1);
      run_move(2, 2, 1, 2, 2'b10, 1'b0, -1);
`ifdef STEP_ENGINE_ABORT_EN
      run_move(10, 5, 10, 5, 2'b01, 1'b0, DSC + 1 + 3 * 5);
      run_move(5, 4, 5, 5, 2'b10, 1'b0, 1);
`endif

      for (int n = 0; n < 30; n++) begin
         l    = $urandom_range(0, 12);
         p    = $urandom_range(1, 8);
         hold = 1'($urandom_range(0, 1));
         ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DSC + 1 + l * peff_of(p)) : -1;
         run_move(l, p, $urandom_range(0, 15), $urandom_range(0, 15),
                  MOTORS'($urandom), hold, ab);
         if (!hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      reset_mid_run();
      run_move(3, 6, 2, 3, 2'b11, 1'b0, -1);
      run_move(0, 1, 0, 0, 2'b00, 1'b0, -1);

      rec_valid = 1'b0;
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
